mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: maximum consecutive data grants while a fetch waits.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles in BUSY without mem_ack before abort.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch request, held high until if_ready.
REQ-006 if_addr  in  32  fetch address (PCF).
REQ-007 if_rdata  out  32  fetched instruction.
REQ-008 if_ready  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request, held high until d_ready.
REQ-010 d_we  in  1  data write enable (MemWriteM).
REQ-011 d_addr  in  32  data address (ALUOutM).
REQ-012 d_wdata  in  32  store data (WriteDataM).
REQ-013 d_rdata  out  32  load data (ReadDataM).
REQ-014 d_ready  out  1  one-cycle data completion pulse.
REQ-015 mem_req  out  1  request to the single-port memory, held until mem_ack or abort.
REQ-016 mem_we  out  1  memory write strobe.
REQ-017 mem_addr  out  32  registered memory address.
REQ-018 mem_wdata  out  32  registered memory write data.
REQ-019 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-020 mem_ack  in  1  memory completion, one cycle.
REQ-021 err  out  1  one-cycle timeout pulse, coincident with the ready pulse of the aborted port.
REQ-022 stall_if  out  1  high whenever if_req is high and if_ready is low (feeds StallF).

Function
REQ-023 FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
REQ-024 IDLE, d_req only -> BUSY_D; if_req only -> BUSY_IF; neither -> IDLE.
REQ-025 IDLE, both requests -> BUSY_D unless starve_cnt == STARVE_LIMIT, then BUSY_IF.
REQ-026 starve_cnt increments when data is granted while if_req high; clears on any fetch grant; saturates at STARVE_LIMIT.
REQ-027 On grant edge: mem_addr, mem_wdata, mem_we (d_we for data, 0 for fetch) registered; mem_req = 1 from the next cycle.
REQ-028 BUSY_x with mem_ack -> RESP: mem_req drops, mem_rdata captured into if_rdata or d_rdata (reads only; writes leave d_rdata unchanged).
REQ-029 RESP: the granted port's ready = 1 for exactly one cycle, then IDLE; no request is accepted in RESP.
REQ-030 Minimum latency, grant edge to ready: 2 cycles (mem_ack in the first BUSY cycle); back-to-back transactions spaced at least 3 cycles.
REQ-031 wait_cnt clears on grant and increments each BUSY cycle without mem_ack; at wait_cnt == TIMEOUT -> RESP with err = 1, captured rdata = 0, mem_req dropped.
REQ-032 mem_ack outside BUSY is ignored.
REQ-033 A request input changing while in BUSY does not affect the in-flight transaction.

Reset
REQ-034 On reset low, immediately: state IDLE, starve_cnt = 0, wait_cnt = 0, all outputs 0, if_rdata = d_rdata = 0.
REQ-035 Reset mid-transaction drops the transaction; no ready pulse follows reset release.

Structure
REQ-036 Package arm_mem_pkg holds the state enum, the 32-bit address/data width constants and the default STARVE_LIMIT and TIMEOUT values.
REQ-037 Sub-module mem_timeout implements the wait_cnt watchdog (clear, enable, expired).

Verification
REQ-038 Fetch only, addr 0x00000008, mem_ack 1 cycle after mem_req, mem_rdata 0xE3A00005 -> if_ready 2 cycles after grant, if_rdata 0xE3A00005, err 0.
REQ-039 Store, d_addr 0x64, d_wdata 0x7, d_we 1 -> mem_we 1, mem_addr 0x64, mem_wdata 0x7; d_ready pulses; d_rdata unchanged.
REQ-040 if_req and d_req held high continuously, STARVE_LIMIT 3 -> grant order D,D,D,IF,D,D,D,IF.
REQ-041 mem_ack never asserted, TIMEOUT 15 -> after 15 BUSY cycles err and d_ready pulse together, d_rdata 0, mem_req 0.
REQ-042 reset asserted during BUSY_D -> all outputs 0 immediately; after release no ready pulse; the next request is served normally.
REQ-043 mem_ack pulsed while IDLE -> no state change, no ready pulse.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared widths, default arbitration limits and FSM state encoding for the
// instruction/data memory arbiter.
package arm_mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEF_STARVE_LIMIT = 3;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RESP    = 2'd3
  } arbState_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and single-port memory signals around the arbiter.
interface mem_arbiter_if;
  import arm_mem_pkg::*;

  // Requesters hold *_req (and address/data) until their one-cycle *_ready;
  // the memory answers a held mem_req with a one-cycle mem_ack.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              err;
  logic              stall_if;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr,
           mem_wdata, err, stall_if
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr,
           mem_wdata, err, stall_if
  );
endinterface

// File: rtl/mem_timeout.sv
// Watchdog counting BUSY cycles without a memory acknowledge; expired fires on
// the TIMEOUT-th such cycle so the abort edge lands exactly TIMEOUT cycles in.
module mem_timeout
  import arm_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CW-1:0] waitCnt;

  assign expired = enable && (waitCnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (clear) begin
      waitCnt <= '0;
    end else if (enable && (waitCnt != CW'(TIMEOUT))) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, preferring
// data but forcing a fetch after STARVE_LIMIT data grants, with a no-ack watchdog.
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic [1:0]   dbgState
);
  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] BUSY_IF = ST_BUSY_IF;
  localparam logic [1:0] BUSY_D  = ST_BUSY_D;
  localparam logic [1:0] RESP    = ST_RESP;
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [1:0]    state;
  logic [SW-1:0] starveCnt;
  logic          starved;
  logic          inBusy;
  logic          grantD;
  logic          grantIf;
  logic          expired;

  assign inBusy  = (state == BUSY_IF) || (state == BUSY_D);
  assign starved = (starveCnt == SW'(STARVE_LIMIT));
  assign grantD  = (state == IDLE) && bus.d_req && !(bus.if_req && starved);
  assign grantIf = (state == IDLE) && bus.if_req && !grantD;

  // Reset gating keeps the stall output low while the arbiter is held in reset.
  assign bus.stall_if = reset && bus.if_req && !bus.if_ready;
  assign dbgState     = state;

  mem_timeout #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (grantD || grantIf),
    .enable  (inBusy && !bus.mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      starveCnt     <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_ready  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_ready   <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantD || grantIf) begin
            state         <= grantD ? BUSY_D : BUSY_IF;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= grantD && bus.d_we;
            bus.mem_addr  <= grantD ? bus.d_addr : bus.if_addr;
            bus.mem_wdata <= grantD ? bus.d_wdata : '0;
            if (grantIf) begin
              starveCnt <= '0;
            end else if (bus.if_req && !starved) begin
              starveCnt <= starveCnt + 1'b1;
            end
          end
        end
        BUSY_IF, BUSY_D: begin
          if (bus.mem_ack || expired) begin
            state       <= RESP;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.err     <= !bus.mem_ack;
            if (state == BUSY_D) begin
              bus.d_ready <= 1'b1;
              // A completed write leaves the last load data in place.
              if (!(bus.mem_ack && bus.mem_we)) begin
                bus.d_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
              end
            end else begin
              bus.if_ready <= 1'b1;
              bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
            end
          end
        end
        RESP: begin
          state        <= IDLE;
          bus.if_ready <= 1'b0;
          bus.d_ready  <= 1'b0;
          bus.err      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, load/store, starvation
// ordering, timeout abort, mid-transaction reset and stray acknowledges.
module tb_mem_arbiter;
  import arm_mem_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbgState;
  int         checkCnt = 0;
  int         passCnt = 0;
  logic [1:0] expQ[$];

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // Clock and global time bound
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Driver and checking tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt = checkCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitMemReq(input string tag);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, 32'(bus.mem_req), 32'd1);
  endtask

  task automatic ackMem(input logic [31:0] data);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // Directed sequence
  initial begin
    logic [1:0] expGrant;
    logic [31:0] ackData;

    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;

    // Reset state
    tick();
    check("rst_state", 32'(dbgState), 32'(ST_IDLE));
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_readies", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
    check("rst_err_stall", {30'd0, bus.err, bus.stall_if}, 32'd0);
    reset = 1'b1;
    tick();

    // Fetch, minimum latency: ack during the first BUSY cycle
    bus.if_req = 1; bus.if_addr = 32'h0000_0008;
    #1 check("fetch_stall_pre", 32'(bus.stall_if), 32'd1);
    tick();
    check("fetch_state_busy", 32'(dbgState), 32'(ST_BUSY_IF));
    check("fetch_mem_req", 32'(bus.mem_req), 32'd1);
    check("fetch_mem_addr", bus.mem_addr, 32'h0000_0008);
    check("fetch_mem_we", 32'(bus.mem_we), 32'd0);
    ackMem(32'hE3A0_0005);
    check("fetch_if_ready", 32'(bus.if_ready), 32'd1);
    check("fetch_if_rdata", bus.if_rdata, 32'hE3A0_0005);
    check("fetch_err", 32'(bus.err), 32'd0);
    check("fetch_mem_req_drop", 32'(bus.mem_req), 32'd0);
    check("fetch_stall_done", 32'(bus.stall_if), 32'd0);
    bus.if_req = 0;
    tick();
    check("fetch_ready_pulse", 32'(bus.if_ready), 32'd0);
    check("fetch_back_idle", 32'(dbgState), 32'(ST_IDLE));

    // Load to give d_rdata a known value
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    tick();
    check("load_mem_we", 32'(bus.mem_we), 32'd0);
    ackMem(32'h1234_5678);
    check("load_d_ready", 32'(bus.d_ready), 32'd1);
    check("load_d_rdata", bus.d_rdata, 32'h1234_5678);
    bus.d_req = 0;
    tick();

    // Store; request inputs change while BUSY and must not leak through
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h64; bus.d_wdata = 32'h7;
    tick();
    check("store_mem_we", 32'(bus.mem_we), 32'd1);
    check("store_mem_addr", bus.mem_addr, 32'h64);
    check("store_mem_wdata", bus.mem_wdata, 32'h7);
    bus.d_addr = 32'hFFF0; bus.d_we = 0; bus.d_wdata = 32'h99;
    tick();
    check("store_hold_addr", bus.mem_addr, 32'h64);
    check("store_hold_we", 32'(bus.mem_we), 32'd1);
    ackMem(32'hDEAD_BEEF);
    check("store_d_ready", 32'(bus.d_ready), 32'd1);
    check("store_d_rdata_kept", bus.d_rdata, 32'h1234_5678);
    bus.d_req = 0;
    tick();
    check("store_ready_pulse", 32'(bus.d_ready), 32'd0);

    // Both requesters held high: D,D,D,IF,D,D,D,IF
    for (int i = 0; i < 2; i++) begin
      expQ.push_back(ST_BUSY_D); expQ.push_back(ST_BUSY_D);
      expQ.push_back(ST_BUSY_D); expQ.push_back(ST_BUSY_IF);
    end
    bus.if_req = 1; bus.if_addr = 32'h100; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    for (int i = 0; i < 8; i++) begin
      waitMemReq("starve");
      expGrant = expQ.pop_front();
      check("starve_grant", 32'(dbgState), 32'(expGrant));
      ackData = 32'h1000 + 32'(i);
      ackMem(ackData);
      if (expGrant == ST_BUSY_D) begin
        check("starve_d_ready", 32'(bus.d_ready), 32'd1);
        check("starve_d_rdata", bus.d_rdata, ackData);
      end else begin
        check("starve_if_ready", 32'(bus.if_ready), 32'd1);
        check("starve_if_rdata", bus.if_rdata, ackData);
      end
    end
    bus.if_req = 0; bus.d_req = 0;
    tick();
    check("starve_queue_empty", 32'(expQ.size()), 32'd0);

    // Timeout: no ack, abort after 15 BUSY cycles
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
    tick();
    for (int i = 1; i < 15; i++) tick();
    check("tmo_still_busy", 32'(dbgState), 32'(ST_BUSY_D));
    check("tmo_req_held", 32'(bus.mem_req), 32'd1);
    check("tmo_no_err_yet", 32'(bus.err), 32'd0);
    tick();
    check("tmo_err", 32'(bus.err), 32'd1);
    check("tmo_d_ready", 32'(bus.d_ready), 32'd1);
    check("tmo_d_rdata", bus.d_rdata, 32'd0);
    check("tmo_mem_req", 32'(bus.mem_req), 32'd0);
    bus.d_req = 0;
    tick();
    check("tmo_err_pulse", 32'(bus.err), 32'd0);

    // Reset during BUSY_D
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'h55;
    tick();
    check("rmid_busy", 32'(dbgState), 32'(ST_BUSY_D));
    #2 reset = 1'b0;
    #1;
    check("rmid_state", 32'(dbgState), 32'(ST_IDLE));
    check("rmid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rmid_mem_we", 32'(bus.mem_we), 32'd0);
    check("rmid_mem_wdata", bus.mem_wdata, 32'd0);
    check("rmid_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
    tick();
    bus.d_req = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rmid_no_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
    end
    bus.if_req = 1; bus.if_addr = 32'h20;
    tick();
    check("rmid_next_addr", bus.mem_addr, 32'h20);
    ackMem(32'hA5A5_0001);
    check("rmid_next_ready", 32'(bus.if_ready), 32'd1);
    check("rmid_next_rdata", bus.if_rdata, 32'hA5A5_0001);
    bus.if_req = 0;
    tick();

    // Stray ack while IDLE
    ackMem(32'hFFFF_FFFF);
    check("stray_state", 32'(dbgState), 32'(ST_IDLE));
    check("stray_readies", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
    check("stray_if_rdata", bus.if_rdata, 32'hA5A5_0001);
    tick();
    check("stray_state_later", 32'(dbgState), 32'(ST_IDLE));

    // Final report
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
